branch_update_ctrl: RTL and testbench

Sequencer that owns the write port of the two-level branch predictor. It accepts resolved-branch records from ROB commit, buffers them in a small FIFO, and performs an atomic read-modify-write of the 2-bit saturating counter for each record. The read uses the predictor's ROB read port and the write uses its edge-triggered write port. It sits between the ROB commit stage and the predictor; the PC read port is untouched.

---
 rtl/bp_pkg.sv | 37 +++
 rtl/bp_update_fifo.sv | 47 ++++
 rtl/branch_update_ctrl.sv | 119 +++++++++++
 tb/tb_branch_update_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor update path.
package bp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      GAP   = 2'd3
   } state_t;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   localparam int BP_ADDR_W = 32;

   // Layout of one resolved-branch record as it sits in the FIFO (msb first).
   typedef struct packed {
      logic [BP_ADDR_W-1:0] addr;
      logic                 taken;
      logic                 pred;
   } res_rec_t;

   // 2-bit saturating counter step toward the actual outcome.
   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      logic [1:0] r;
      r = cnt;
      if (taken) begin
         if (cnt != ST) r = cnt + 2'b01;
      end else begin
         if (cnt != SNT) r = cnt - 2'b01;
      end
      return r;
   endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Synchronous FIFO with wrap bit on each pointer to tell full from empty.
module bp_update_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 34
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Pointer advance; reset empties the FIFO and discards contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage write; contents are don't-care until a push makes them valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/branch_update_ctrl.sv
// Read-modify-write sequencer for the branch predictor's 2-bit counters.
//
// state | meaning
// IDLE  | nothing in flight; pop the next record when the FIFO has one
// READ  | bp_rd_addr = cur_addr; new counter value captured at cycle end
// WRITE | bp_wr_en high for this single cycle
// GAP   | bp_wr_en low so every write gets its own rising edge; may pop next
module branch_update_ctrl
   import bp_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              res_valid,
   output logic              res_ready,
   input  logic [ADDR_W-1:0] res_addr,
   input  logic              res_taken,
   input  logic              res_pred,
   output logic [ADDR_W-1:0] bp_rd_addr,
   input  logic [1:0]        bp_rd_data,
   output logic              bp_wr_en,
   output logic [ADDR_W-1:0] bp_wr_addr,
   output logic [1:0]        bp_wr_data,
   output logic              busy,
   output logic [CNT_W-1:0]  mispred_cnt
);

   localparam int REC_W = ADDR_W + 2;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state;
   state_t            state_nxt;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [REC_W-1:0]  fifo_rd;
   logic [ADDR_W-1:0] cur_addr;
   logic              cur_taken;
   logic [1:0]        cur_cnt;
   logic              wr_en_q;

   bp_update_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (res_valid),
      .wr_data ({res_addr, res_taken, res_pred}),
      .pop     (pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign res_ready   = !fifo_full;
   assign busy        = (state != IDLE) || !fifo_empty;
   assign bp_rd_addr  = cur_addr;
   assign bp_wr_addr  = cur_addr;
   assign bp_wr_data  = cur_cnt;
   assign bp_wr_en    = wr_en_q;

   // Next-state and pop decode.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = READ;
            end
         end
         READ:  state_nxt = WRITE;
         WRITE: state_nxt = GAP;
         GAP: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = READ;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Current record, updated counter, write strobe and mispredict count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_addr    <= '0;
         cur_taken   <= 1'b0;
         cur_cnt     <= SNT;
         wr_en_q     <= 1'b0;
         mispred_cnt <= '0;
      end else begin
         wr_en_q <= (state == READ);
         if (pop) begin
            cur_addr  <= fifo_rd[REC_W-1:2];
            cur_taken <= fifo_rd[1];
            if ((fifo_rd[1] != fifo_rd[0]) && (mispred_cnt != '1))
               mispred_cnt <= mispred_cnt + CNT_ONE;
         end
         // The saturated value is captured with the read so the write
         // outputs come straight from flops.
         if (state == READ) cur_cnt <= sat_update(bp_rd_data, cur_taken);
      end
   end

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Self-checking bench: table vectors, hand sequences and random traffic
// against a simple predictor-memory and record-queue model.
module tb_branch_update_ctrl;

   localparam int AW = 32;
   localparam int QN = 512;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          res_valid = 1'b0;
   logic [AW-1:0] res_addr = '0;
   logic          res_taken = 1'b0;
   logic          res_pred = 1'b0;

   logic          res_ready, bp_wr_en, busy;
   logic [AW-1:0] bp_rd_addr, bp_wr_addr;
   logic [1:0]    bp_rd_data, bp_wr_data;
   logic [15:0]   mispred_cnt;

   logic          res_ready4, bp_wr_en4, busy4;
   logic [AW-1:0] bp_rd_addr4, bp_wr_addr4;
   logic [1:0]    bp_rd_data4, bp_wr_data4;
   logic [3:0]    mispred_cnt4;

   logic [1:0]    pmem [64];

   always #5 clk = ~clk;

   assign bp_rd_data  = pmem[bp_rd_addr[5:0]];
   assign bp_rd_data4 = pmem[bp_rd_addr4[5:0]];

   branch_update_ctrl #(.ADDR_W(AW), .FIFO_DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr),
      .res_taken(res_taken), .res_pred(res_pred),
      .bp_rd_addr(bp_rd_addr), .bp_rd_data(bp_rd_data),
      .bp_wr_en(bp_wr_en), .bp_wr_addr(bp_wr_addr), .bp_wr_data(bp_wr_data),
      .busy(busy), .mispred_cnt(mispred_cnt)
   );

   branch_update_ctrl #(.ADDR_W(AW), .FIFO_DEPTH(4), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .res_valid(res_valid), .res_ready(res_ready4), .res_addr(res_addr),
      .res_taken(res_taken), .res_pred(res_pred),
      .bp_rd_addr(bp_rd_addr4), .bp_rd_data(bp_rd_data4),
      .bp_wr_en(bp_wr_en4), .bp_wr_addr(bp_wr_addr4), .bp_wr_data(bp_wr_data4),
      .busy(busy4), .mispred_cnt(mispred_cnt4)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          sent_n = 0;
   int          wr_n = 0;
   int          last_wr = -1;
   int          mis_exp = 0;
   logic [AW-1:0] q_addr [QN];
   logic          q_taken [QN];
   int            wr_cyc [QN];
   logic [1:0]    wr_dat [QN];

   typedef struct {
      logic [AW-1:0] addr;
      logic          taken;
      logic          pred;
      logic [1:0]    exp_data;
      int            mis_inc;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [1:0] ref_sat(input logic [1:0] c, input logic t);
      int v;
      v = int'(c) + (t ? 1 : -1);
      if (v < 0) v = 0;
      if (v > 3) v = 3;
      return 2'(v);
   endfunction

   function automatic int min15(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   // One clock: advance to the falling edge and check any write seen there.
   task automatic tick();
      logic [1:0] e;
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         wr_n    = sent_n;
         last_wr = -1;
      end else if (bp_wr_en) begin
         if (wr_n >= sent_n) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr 0x%0h with no pending record (cycle %0d)", bp_wr_addr, cyc);
         end else begin
            e = ref_sat(pmem[q_addr[wr_n][5:0]], q_taken[wr_n]);
            chk("wr_addr", 64'(bp_wr_addr), 64'(q_addr[wr_n]));
            chk("wr_data", 64'(bp_wr_data), 64'(e));
            chk("dut4_wr_en", 64'(bp_wr_en4), 64'd1);
            chk("dut4_wr_data", 64'(bp_wr_data4), 64'(e));
            chk("dut4_wr_addr", 64'(bp_wr_addr4), 64'(q_addr[wr_n]));
            if (last_wr >= 0 && (cyc - last_wr) < 3) begin
               checks++;
               errors++;
               $display("FAIL wr_spacing: got %0d cycles between writes, expected at least 3", cyc - last_wr);
            end
            pmem[q_addr[wr_n][5:0]] = e;
            wr_cyc[wr_n] = cyc;
            wr_dat[wr_n] = bp_wr_data;
            last_wr = cyc;
            wr_n++;
         end
      end
   endtask

   // Offer one record; it is taken at the next rising edge once ready.
   task automatic send(input logic [AW-1:0] a, input logic t, input logic p, output int acc_cyc);
      int n;
      n = 0;
      res_valid = 1'b1;
      res_addr  = a;
      res_taken = t;
      res_pred  = p;
      while (!res_ready && n < 50) begin
         tick();
         n++;
      end
      if (!res_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: res_ready stuck low for %0d cycles", n);
      end else begin
         q_addr[sent_n]  = a;
         q_taken[sent_n] = t;
         sent_n++;
         if (t != p) mis_exp++;
      end
      acc_cyc = cyc;
      tick();
      res_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((wr_n < sent_n || busy) && n < 500) begin
         tick();
         n++;
      end
      chk("drain_writes", 64'(wr_n), 64'(sent_n));
      chk("drain_busy", 64'(busy), 64'd0);
      chk("drain_busy4", 64'(busy4), 64'd0);
      chk("drain_ready4", 64'(res_ready4), 64'd1);
      chk("mispred_cnt", 64'(mispred_cnt), 64'(mis_exp));
      chk("mispred_cnt4", 64'(mispred_cnt4), 64'(min15(mis_exp)));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      mis_exp = 0;
      tick();
   endtask

   initial begin
      int acc;
      int base;
      int m0;
      int n;
      logic [AW-1:0] ra;
      logic rt;
      logic rp;

      for (int i = 0; i < 64; i++) pmem[i] = 2'(i >> 4);

      tbl[0] = '{32'h0000_0010, 1'b1, 1'b0, 2'b10, 1};
      tbl[1] = '{32'h0000_0030, 1'b1, 1'b1, 2'b11, 0};
      tbl[2] = '{32'h0000_0000, 1'b0, 1'b0, 2'b00, 0};
      tbl[3] = '{32'hABCD_0024, 1'b0, 1'b1, 2'b01, 1};
      tbl[4] = '{32'h0000_0014, 1'b1, 1'b1, 2'b10, 0};
      tbl[5] = '{32'h8000_0038, 1'b0, 1'b0, 2'b10, 0};

      tick();
      #1;
      chk("rst_ready", 64'(res_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_wr_en", 64'(bp_wr_en), 64'd0);
      chk("rst_wr_addr", 64'(bp_wr_addr), 64'd0);
      chk("rst_rd_addr", 64'(bp_rd_addr), 64'd0);
      chk("rst_wr_data", 64'(bp_wr_data), 64'd0);
      chk("rst_mispred", 64'(mispred_cnt), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Table vectors: one record at a time, check data, latency, mispredicts.
      for (int i = 0; i < 6; i++) begin
         base = sent_n;
         m0   = mis_exp;
         send(tbl[i].addr, tbl[i].taken, tbl[i].pred, acc);
         drain();
         chk("tbl_wr_data", 64'(wr_dat[base]), 64'(tbl[i].exp_data));
         chk("tbl_latency", 64'(wr_cyc[base] - acc), 64'd3);
         chk("tbl_mispred", 64'(mispred_cnt), 64'(m0 + tbl[i].mis_inc));
      end

      // Burst of six back to back into a four-entry FIFO.
      base = sent_n;
      for (int i = 0; i < 6; i++) send(32'h100 + 32'(i * 4), 1'(i), 1'b1, acc);
      chk("burst_ready_full", 64'(res_ready), 64'd0);
      tick();
      chk("burst_ready_pop_cycle", 64'(res_ready), 64'd0);
      tick();
      chk("burst_ready_after_pop", 64'(res_ready), 64'd1);
      drain();
      for (int i = 1; i < 6; i++)
         chk("burst_spacing", 64'(wr_cyc[base + i] - wr_cyc[base + i - 1]), 64'd3);

      // Reset while a write is on the bus with more records queued.
      for (int i = 0; i < 3; i++) send(32'h200 + 32'(i * 4), 1'b1, 1'b0, acc);
      n = 0;
      while (!bp_wr_en && n < 20) begin
         tick();
         n++;
      end
      chk("rstw_saw_write", 64'(bp_wr_en), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstw_wr_en", 64'(bp_wr_en), 64'd0);
      chk("rstw_busy", 64'(busy), 64'd0);
      chk("rstw_ready", 64'(res_ready), 64'd1);
      chk("rstw_mispred", 64'(mispred_cnt), 64'd0);
      chk("rstw_wr_addr", 64'(bp_wr_addr), 64'd0);
      mis_exp = 0;
      tick();
      tick();
      rst_n = 1'b1;
      base = wr_n;
      for (int i = 0; i < 15; i++) tick();
      chk("rstw_no_stale_write", 64'(wr_n), 64'(base));
      chk("rstw_busy_after", 64'(busy), 64'd0);
      chk("rstw_ready_after", 64'(res_ready), 64'd1);

      // Random traffic with idle gaps and address aliasing.
      for (int i = 0; i < 150; i++) begin
         n = $urandom_range(0, 3);
         for (int k = 0; k < n; k++) tick();
         ra = $urandom;
         rt = 1'($urandom);
         rp = 1'($urandom);
         send(ra, rt, rp, acc);
      end
      drain();

      // Twenty mispredicts from zero: 16-bit counter counts, 4-bit saturates.
      do_reset();
      for (int i = 0; i < 20; i++) send(32'h300 + 32'(i), 1'(i), !1'(i), acc);
      drain();
      chk("sat_cnt16", 64'(mispred_cnt), 64'd20);
      chk("sat_cnt4", 64'(mispred_cnt4), 64'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
